countdown_timer: RTL and testbench

- 6-digit BCD countdown timer (MM:SS.cc, 10 ms resolution), the count-down counterpart of the stopwatch.
- Loads a BCD preset, decrements once per 10 ms tick while running, stops at 00:00.00 and flags expiry with a one-cycle alarm pulse.
- Output feeds the same display mux as the stopwatch. Active only in timer mode (model == 2'b11).

---
 rtl/countdown_timer_pkg.sv | 30 +++
 rtl/countdown_timer_digit.sv | 35 +++
 rtl/countdown_timer.sv | 117 +++++++++++
 tb/tb_countdown_timer.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/countdown_timer_pkg.sv
// Shared definitions for the BCD countdown timer.
//   state_t      : FSM encoding (IDLE / RUN / DONE)
//   MODE_*       : display/function mode codes shared with the stopwatch
//   DIG_MAX9/5   : largest legal value of a decimal / tens-of-seconds digit
//   digit_max()  : digit maximum by chain position (0 = c0 ... 5 = m1)
//   bcd_sat()    : clamp a raw nibble to a digit maximum
package countdown_timer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [1:0] MODE_STOPWATCH = 2'b10;
   localparam logic [1:0] MODE_TIMER     = 2'b11;

   localparam logic [3:0] DIG_MAX9 = 4'd9;
   localparam logic [3:0] DIG_MAX5 = 4'd5;

   // Position 3 is the tens-of-seconds digit (s1); all others are 0..9.
   function automatic logic [3:0] digit_max(input int pos);
      return (pos == 3) ? DIG_MAX5 : DIG_MAX9;
   endfunction

   function automatic logic [3:0] bcd_sat(input logic [3:0] d, input logic [3:0] max);
      return (d > max) ? max : d;
   endfunction

endpackage

// File: rtl/countdown_timer_digit.sv
// One 4-bit BCD down-counter digit.
//   i_clk, i_rst   : clock, async active-high reset
//   i_dec_in       : decrement request (tick or borrow from lower digit)
//   i_load         : load i_load_val, clamped to MAX
//   i_clr          : synchronous clear to 0 (beats load and decrement)
//   o_digit        : registered digit value
//   o_borrow_out   : decrement request to the next higher digit
module bcd_down_digit
   import countdown_timer_pkg::*;
#(
   parameter logic [3:0] MAX = DIG_MAX9
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_dec_in,
   input  logic       i_load,
   input  logic [3:0] i_load_val,
   input  logic       i_clr,
   output logic [3:0] o_digit,
   output logic       o_borrow_out
);

   logic [3:0] r_digit;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)         r_digit <= 4'd0;
      else if (i_clr)    r_digit <= 4'd0;
      else if (i_load)   r_digit <= bcd_sat(i_load_val, MAX);
      else if (i_dec_in) r_digit <= (r_digit == 4'd0) ? MAX : r_digit - 4'd1;
   end

   assign o_digit      = r_digit;
   assign o_borrow_out = i_dec_in & (r_digit == 4'd0);

endmodule

// File: rtl/countdown_timer.sv
// 6-digit BCD countdown timer, MM:SS.cc with 10 ms resolution.
//   clk / rst          : i_clk, i_rst (async, active-high)
//   i_model            : mode; counts only in MODE_TIMER
//   i_run              : level, 1 = count, 0 = pause
//   i_clear            : sync clear to 0, any state
//   i_load, i_preset   : sync preset load (ignored while running), BCD {m1,m0,s1,s0,c1,c0}
//   o_count_down_num   : current value, same packing as i_preset
//   o_expired          : high while in DONE
//   o_alarm            : one-cycle pulse on reaching zero
module countdown_timer
   import countdown_timer_pkg::*;
#(
   parameter int TICK_DIV = 500_000
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [1:0]  i_model,
   input  logic        i_run,
   input  logic        i_clear,
   input  logic        i_load,
   input  logic [23:0] i_preset,
   output logic [23:0] o_count_down_num,
   output logic        o_expired,
   output logic        o_alarm
);

   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);

   state_t        r_state, w_state_nxt;
   logic [CW-1:0] r_cnt;
   logic          r_expired, r_alarm;
   logic          w_expired_nxt, w_alarm_nxt;
   logic          w_tick, w_load_acc, w_terminal, w_run_ok;
   logic [23:0]   w_value;
   logic [5:0]    w_dec, w_borrow;

   assign w_tick     = (r_state == ST_RUN) && (r_cnt == TICK_LAST);
   assign w_load_acc = i_load && (r_state != ST_RUN);
   assign w_run_ok   = i_run && (i_model == MODE_TIMER);
   // An m1 borrow would mean the chain wrapped past zero; it cannot happen
   // because zero is terminal, but if it ever did, stop rather than keep counting.
   assign w_terminal = (w_tick && (w_value == 24'h000001)) || w_borrow[5];

   // Digit chain: c0 takes the tick, every higher digit takes the borrow below it.
   for (genvar g = 0; g < 6; g++) begin : g_dig
      if (g == 0) begin : g_lsd
         assign w_dec[g] = w_tick;
      end else begin : g_hsd
         assign w_dec[g] = w_borrow[g-1];
      end
      bcd_down_digit #(.MAX(digit_max(g))) u_dig (
         .i_clk        (i_clk),
         .i_rst        (i_rst),
         .i_dec_in     (w_dec[g]),
         .i_load       (w_load_acc),
         .i_load_val   (i_preset[4*g +: 4]),
         .i_clr        (i_clear),
         .o_digit      (w_value[4*g +: 4]),
         .o_borrow_out (w_borrow[g])
      );
   end

   // State register
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) r_state <= ST_IDLE;
      else       r_state <= w_state_nxt;
   end

   // Next-state logic: clear > load > run/tick behaviour
   always_comb begin
      w_state_nxt = r_state;
      if (i_clear)         w_state_nxt = ST_IDLE;
      else if (w_load_acc) w_state_nxt = ST_IDLE;
      else begin
         case (r_state)
            ST_IDLE: if (w_run_ok && (w_value != 24'h0)) w_state_nxt = ST_RUN;
            // Reaching zero wins over a pause on the same edge.
            ST_RUN:  if (w_terminal)    w_state_nxt = ST_DONE;
                     else if (!w_run_ok) w_state_nxt = ST_IDLE;
            ST_DONE: w_state_nxt = ST_DONE;
            default: w_state_nxt = ST_IDLE;
         endcase
      end
   end

   // Output next-values (registered below)
   always_comb begin
      w_alarm_nxt   = w_terminal && !i_clear;
      w_expired_nxt = r_expired;
      if (i_clear || w_load_acc) w_expired_nxt = 1'b0;
      else if (w_terminal)       w_expired_nxt = 1'b1;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_alarm   <= 1'b0;
         r_expired <= 1'b0;
      end else begin
         r_alarm   <= w_alarm_nxt;
         r_expired <= w_expired_nxt;
      end
   end

   // Tick prescaler: runs only while staying in RUN so every RUN entry
   // starts a fresh TICK_DIV-cycle interval.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)                                              r_cnt <= '0;
      else if ((r_state == ST_RUN) && (w_state_nxt == ST_RUN)) r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
      else                                                    r_cnt <= '0;
   end

   assign o_count_down_num = w_value;
   assign o_expired        = r_expired;
   assign o_alarm          = r_alarm;

endmodule

// File: tb/tb_countdown_timer.sv
module tb_countdown_timer;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  model;
   logic        run, clear, load;
   logic [23:0] preset;
   logic [23:0] count_down_num;
   logic        expired, alarm;

   always #5 clk = ~clk;

   countdown_timer #(.TICK_DIV(4)) dut (
      .i_clk            (clk),
      .i_rst            (rst),
      .i_model          (model),
      .i_run            (run),
      .i_clear          (clear),
      .i_load           (load),
      .i_preset         (preset),
      .o_count_down_num (count_down_num),
      .o_expired        (expired),
      .o_alarm          (alarm)
   );

   typedef struct {
      logic        clr, ld, rn;
      logic [1:0]  md;
      logic [23:0] pre;
      logic [23:0] e_val;
      logic        e_exp, e_alm;
   } vec_t;

   typedef struct {
      logic [23:0] val;
      logic        exp_;
      logic        alm;
      string       nm;
   } exp_t;

   exp_t sb[$];
   int   n_total = 0;
   int   n_pass  = 0;

   task automatic check_out();
      exp_t e;
      if (sb.size() == 0) begin
         n_total++;
         $display("FAIL scoreboard_empty: no expectation queued");
         return;
      end
      e = sb.pop_front();
      n_total++;
      if (count_down_num !== e.val || expired !== e.exp_ || alarm !== e.alm)
         $display("FAIL %s: got val=%06h exp=%b alm=%b, want val=%06h exp=%b alm=%b",
                  e.nm, count_down_num, expired, alarm, e.val, e.exp_, e.alm);
      else
         n_pass++;
   endtask

   // Drive one cycle of inputs, queue the expected post-edge outputs, compare #1 after the edge.
   task automatic step(input logic c, input logic l, input logic r, input logic [1:0] m,
                       input logic [23:0] p, input logic [23:0] ev, input logic ee,
                       input logic ea, input string nm);
      clear = c; load = l; run = r; model = m; preset = p;
      sb.push_back('{ev, ee, ea, nm});
      @(posedge clk);
      #1;
      check_out();
   endtask

   vec_t tbl[16];

   initial begin
      // Basic count from 00:00.03, TICK_DIV=4: decrements at RUN-entry +4, +8, +12.
      tbl[0]  = '{0,1,0,2'b11,24'h000003, 24'h000003,0,0};
      tbl[1]  = '{0,0,1,2'b11,24'h0,      24'h000003,0,0}; // RUN entry
      tbl[2]  = '{0,0,1,2'b11,24'h0,      24'h000003,0,0};
      tbl[3]  = '{0,0,1,2'b11,24'h0,      24'h000003,0,0};
      tbl[4]  = '{0,0,1,2'b11,24'h0,      24'h000003,0,0};
      tbl[5]  = '{0,0,1,2'b11,24'h0,      24'h000002,0,0}; // cycle 4
      tbl[6]  = '{0,0,1,2'b11,24'h0,      24'h000002,0,0};
      tbl[7]  = '{0,0,1,2'b11,24'h0,      24'h000002,0,0};
      tbl[8]  = '{0,0,1,2'b11,24'h0,      24'h000002,0,0};
      tbl[9]  = '{0,0,1,2'b11,24'h0,      24'h000001,0,0}; // cycle 8
      tbl[10] = '{0,0,1,2'b11,24'h0,      24'h000001,0,0};
      tbl[11] = '{0,0,1,2'b11,24'h0,      24'h000001,0,0};
      tbl[12] = '{0,0,1,2'b11,24'h0,      24'h000001,0,0};
      tbl[13] = '{0,0,1,2'b11,24'h0,      24'h000000,1,1}; // cycle 12: terminal
      tbl[14] = '{0,0,1,2'b11,24'h0,      24'h000000,1,0}; // alarm is one cycle
      tbl[15] = '{0,0,1,2'b11,24'h0,      24'h000000,1,0}; // DONE ignores run

      rst = 1'b1; model = 2'b00; run = 0; clear = 0; load = 0; preset = '0;
      #12;
      sb.push_back('{24'h0, 1'b0, 1'b0, "reset_state"});
      check_out();
      rst = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < 16; i++)
         step(tbl[i].clr, tbl[i].ld, tbl[i].rn, tbl[i].md, tbl[i].pre,
              tbl[i].e_val, tbl[i].e_exp, tbl[i].e_alm, $sformatf("basic[%0d]", i));

      // Borrow chain from DONE: load clears expired, 10:00.00 -> 09:59.99.
      step(0,1,0,2'b11,24'h100000, 24'h100000,0,0, "load_in_done");
      for (int i = 0; i < 4; i++) step(0,0,1,2'b11,0, 24'h100000,0,0, $sformatf("borrow_wait[%0d]", i));
      step(0,0,1,2'b11,0, 24'h095999,0,0, "borrow_chain");

      // Pause 20 cycles, then resume: next decrement exactly 4 cycles after re-entry.
      for (int i = 0; i < 20; i++) step(0,0,0,2'b11,0, 24'h095999,0,0, $sformatf("pause[%0d]", i));
      for (int i = 0; i < 4; i++) step(0,0,1,2'b11,0, 24'h095999,0,0, $sformatf("resume_wait[%0d]", i));
      step(0,0,1,2'b11,0, 24'h095998,0,0, "resume_dec");

      // Load while running is ignored.
      step(0,1,1,2'b11,24'h000500, 24'h095998,0,0, "load_in_run");

      // Stopwatch mode freezes the count.
      for (int i = 0; i < 7; i++) step(0,0,1,2'b10,0, 24'h095998,0,0, $sformatf("mode_sw[%0d]", i));

      // Per-digit saturation.
      step(0,1,0,2'b11,24'h9F7ABC, 24'h995999,0,0, "saturate");

      // Clear beats load.
      step(1,1,0,2'b11,24'h123456, 24'h000000,0,0, "clear_vs_load");

      // Zero value with run=1 never starts and never alarms.
      step(0,1,1,2'b11,24'h000000, 24'h000000,0,0, "load_zero");
      for (int i = 0; i < 6; i++) step(0,0,1,2'b11,0, 24'h000000,0,0, $sformatf("zero_idle[%0d]", i));

      // Clear on the terminal tick: no alarm, no expiry.
      step(0,1,0,2'b11,24'h000001, 24'h000001,0,0, "load_one");
      for (int i = 0; i < 4; i++) step(0,0,1,2'b11,0, 24'h000001,0,0, $sformatf("term_wait[%0d]", i));
      step(1,0,1,2'b11,0, 24'h000000,0,0, "clear_on_terminal");
      for (int i = 0; i < 3; i++) step(0,0,1,2'b11,0, 24'h000000,0,0, $sformatf("after_clear[%0d]", i));

      // Async reset mid-RUN at 05:00.00, checked without any clock edge.
      step(0,1,0,2'b11,24'h050000, 24'h050000,0,0, "load_5min");
      for (int i = 0; i < 3; i++) step(0,0,1,2'b11,0, 24'h050000,0,0, $sformatf("run_5min[%0d]", i));
      #2 rst = 1'b1;
      #1;
      sb.push_back('{24'h0, 1'b0, 1'b0, "async_rst"});
      check_out();
      #1 rst = 1'b0;
      @(posedge clk); #1;
      for (int i = 0; i < 5; i++) step(0,0,1,2'b11,0, 24'h000000,0,0, $sformatf("post_rst[%0d]", i));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
